sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester access controller for the single-port 256x32 SRAM behind `sram_wrapper`. Arbitrates read/write requests from two independent masters (e.g. host loader and 9-bit output streamer), sequences one SRAM access at a time, and returns read data tagged to the owning requester. Sits directly between the requesters and `sram_wrapper`, owning all `cs_n`/`we_n`/`address` drive.

## Interface
- `ADDR_W`, 8, SRAM address width
- `DATA_W`, 32, SRAM word width
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  access request; held high until matching `gnt`
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` high
- `addr0` / `addr1`  in  ADDR_W  access address
- `wdata0` / `wdata1`  in  DATA_W  write data (ignored for reads)
- `gnt0` / `gnt1`  out  1  one-cycle pulse: request accepted, may drop/change `req` next cycle
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds read result for that requester
- `rdata`  out  DATA_W  shared registered read-data bus
- `busy`  out  1  high in any state other than IDLE
- `sram_cs_n`  out  1  SRAM chip select, active-low
- `sram_we_n`  out  1  SRAM write enable, active-low
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_rdata`  in  DATA_W  SRAM read data, valid the cycle after a read access
- `sram_ry`  in  1  SRAM ready; new access issued only when high

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if `sram_ry`=1 and any `req` high, select winner, pulse its `gnt`, latch `we`/`addr`/`wdata` into command registers, go ISSUE. Otherwise stay, no grant.
- Arbitration: round-robin; on simultaneous requests, winner is the requester not granted last. Single request wins immediately. Last-granted pointer resets to 1 (requester 0 wins first contention).
- ISSUE: `sram_cs_n`=0 one cycle; `sram_we_n`=0 for write, 1 for read; `sram_addr`/`sram_wdata` from command registers. Write -> IDLE. Read -> RESP.
- RESP: capture `sram_rdata` into `rdata`; next cycle pulse `rvalid` of owner; -> IDLE.
- All SRAM-side and requester-side outputs registered.
- Reset values: `gnt0/1`=0, `rvalid0/1`=0, `rdata`=0, `busy`=0, `sram_cs_n`=1, `sram_we_n`=1, `sram_addr`=0, `sram_wdata`=0, state IDLE.
- Reset mid-access: abort immediately; no `rvalid` emitted for the aborted read; `sram_cs_n` high in the cycle after `rst` sampled.
- `sram_ry` low in IDLE: requests wait indefinitely; no timeout.
- `req` dropped before `gnt`: request withdrawn, no access.

## Timing
- Grant in cycle T (IDLE), `sram_cs_n` low in T+1.
- Write: complete at end of T+1; next grant possible T+2 (1 access / 2 cycles).
- Read: `sram_rdata` sampled end of T+2, `rvalid`/`rdata` visible T+3; next grant possible T+3 (1 read / 3 cycles).
- `rdata` holds last read value until the next read overwrites it.
- `gnt` never asserted for both requesters in same cycle; never asserted outside IDLE.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority, requester 0 always wins contention; last-granted pointer not implemented.
- Undefined (default): round-robin as above.

## Structure
- Shared package `sram_pkg`: `ADDR_W`/`DATA_W` defaults, state encoding constants (IDLE=0, ISSUE=1, RESP=2), requester ID width.
- One sub-module: `rr_arb2` (2-way round-robin picker: inputs `req[1:0]`, `advance`; outputs one-hot `win[1:0]`; holds last-granted pointer). Bypassed by fixed-priority logic when `SRAM_ARB_FIXED_PRIO_EN` set.

## Test plan
- Reset then single write: `req0`=1, `we0`=1, `addr0`=0x10, `wdata0`=0xDEADBEEF -> `gnt0` at T, `sram_cs_n`=0/`sram_we_n`=0/`sram_addr`=0x10 at T+1, `busy` low at T+2.
- Read-back: `req1`=1, `we1`=0, `addr1`=0x10 -> `gnt1` at T, `rvalid1`=1 with `rdata`=0xDEADBEEF at T+3, `rvalid0` stays 0.
- Contention: `req0`/`req1` both held high, reads at 0x01/0x02 -> grants alternate 0,1,0,1; with `SRAM_ARB_FIXED_PRIO_EN` requester 0 granted every time until it drops `req0`.
- Not ready: `sram_ry`=0 for 5 cycles with `req0` high -> no `gnt0`, `sram_cs_n`=1; `gnt0` in first cycle after `sram_ry` returns high.
- Reset mid-read: assert `rst` in ISSUE of a read -> `sram_cs_n`=1, no `rvalid`, `busy`=0 next cycle; subsequent contention grants requester 0 first.
- Back-to-back writes from requester 0 -> `gnt0` every 2 cycles, addresses 0x00..0x07 written in order.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and sizing for the SRAM arbiter slice.
package sram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Latched command of the granted requester
  typedef struct packed {
    logic              we;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer remembers the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

  logic last_q;

  // On contention the requester not granted last wins
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (win != 2'b00)) begin
      last_q <= win[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester access sequencer for the single-port SRAM.
// Build option: SRAM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins).
module sram_arbiter
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ry
);

  state_t            state_q, state_nxt;
  cmd_t              cmd_q, cmd_nxt;
  logic              rd_pend_q, rd_pend_nxt;
  logic [1:0]        win;
  logic              advance;
  logic [1:0]        gnt_nxt, rvalid_nxt;
  logic [DATA_W-1:0] rdata_nxt, wdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              cs_n_nxt, we_n_nxt;

  assign advance = (state_q == ST_IDLE) && sram_ry;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'b00;
    if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end
  end
`else
  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (advance),
    .win     (win)
  );
`endif

  // Next state and next registered outputs
  always_comb begin
    state_nxt   = state_q;
    cmd_nxt     = cmd_q;
    rd_pend_nxt = 1'b0;
    gnt_nxt     = 2'b00;
    rvalid_nxt  = 2'b00;
    rdata_nxt   = rdata;
    cs_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    addr_nxt    = sram_addr;
    wdata_nxt   = sram_wdata;

    // SRAM data is valid the cycle after RESP; return it to the owner
    if (rd_pend_q) begin
      rdata_nxt  = sram_rdata;
      rvalid_nxt = cmd_q.id[0] ? 2'b10 : 2'b01;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (advance && (win != 2'b00)) begin
          gnt_nxt       = win;
          cmd_nxt.we    = win[1] ? we1 : we0;
          cmd_nxt.id    = ID_W'(win[1]);
          cmd_nxt.addr  = win[1] ? addr1 : addr0;
          cmd_nxt.wdata = win[1] ? wdata1 : wdata0;
          state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cs_n_nxt  = 1'b0;
        we_n_nxt  = ~cmd_q.we;
        addr_nxt  = cmd_q.addr;
        wdata_nxt = cmd_q.wdata;
        state_nxt = cmd_q.we ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        rd_pend_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rd_pend_q  <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      sram_cs_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      state_q    <= state_nxt;
      cmd_q      <= cmd_nxt;
      rd_pend_q  <= rd_pend_nxt;
      gnt0       <= gnt_nxt[0];
      gnt1       <= gnt_nxt[1];
      rvalid0    <= rvalid_nxt[0];
      rvalid1    <= rvalid_nxt[1];
      rdata      <= rdata_nxt;
      busy       <= (state_nxt != ST_IDLE);
      sram_cs_n  <= cs_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_addr  <= addr_nxt;
      sram_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model.
module tb_sram_arbiter;
  import sram_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy, sram_cs_n, sram_we_n;
  logic [DATA_W-1:0] rdata, sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ry = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ry(sram_ry)
  );

  // SRAM model: preloaded pattern, write log, read data one cycle after access
  logic [DATA_W-1:0] mem [256];
  logic [ADDR_W-1:0] wr_log [$];
  logic              mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (!sram_cs_n) begin
      if (!sram_we_n) begin
        mem[sram_addr] <= sram_wdata;
        wr_log.push_back(sram_addr);
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              rst, ry, req0, we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1, we1;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt, rv;
    logic              busy, cs_n, we_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ry, input logic q0, input logic w0,
    input logic [7:0] a0, input logic [31:0] d0,
    input logic q1, input logic w1, input logic [7:0] a1,
    input logic [1:0] g, input logic [1:0] v, input logic b,
    input logic cs, input logic wn, input logic [7:0] a, input logic [31:0] rd);
    vec_t t;
    t.rst = r; t.ry = ry; t.req0 = q0; t.we0 = w0; t.addr0 = a0; t.wdata0 = d0;
    t.req1 = q1; t.we1 = w1; t.addr1 = a1;
    t.gnt = g; t.rv = v; t.busy = b; t.cs_n = cs; t.we_n = wn; t.addr = a; t.rdata = rd;
    return t;
  endfunction

  localparam int NV = 20;
  vec_t vt [NV];

  int          ng, nrv, lastc, base;
  logic [31:0] exp_id;

  initial begin
    // rst ry  req0 we0 addr0  wdata0        req1 we1 addr1 | gnt  rv   busy cs we addr   rdata
    vt[0]  = mk(1, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h00, 32'h0);
    vt[1]  = mk(0, 1, 1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 2'b01, 2'b00, 1, 1, 1, 8'h00, 32'h0);
    vt[2]  = mk(0, 1, 0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 0, 8'h10, 32'h0);
    vt[3]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h10, 32'h0);
    vt[4]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        1, 0, 8'h10, 2'b10, 2'b00, 1, 1, 1, 8'h10, 32'h0);
    vt[5]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h10, 2'b00, 2'b00, 1, 0, 1, 8'h10, 32'h0);
    vt[6]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h10, 32'h0);
    vt[7]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b10, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    vt[8]  = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    for (int i = 9; i < 14; i++)
      vt[i] = mk(0, 0, 1, 1, 8'h20, 32'h12345678, 0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    vt[14] = mk(0, 1, 1, 1, 8'h20, 32'h12345678, 0, 0, 8'h00, 2'b01, 2'b00, 1, 1, 1, 8'h10, 32'hDEADBEEF);
    vt[15] = mk(0, 1, 0, 1, 8'h20, 32'h12345678, 0, 0, 8'h00, 2'b00, 2'b00, 0, 0, 0, 8'h20, 32'hDEADBEEF);
    vt[16] = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h20, 32'hDEADBEEF);
    vt[17] = mk(0, 1, 1, 0, 8'h20, 32'h0,        0, 0, 8'h00, 2'b01, 2'b00, 1, 1, 1, 8'h20, 32'hDEADBEEF);
    vt[18] = mk(1, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h00, 32'h0);
    vt[19] = mk(0, 1, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 2'b00, 2'b00, 0, 1, 1, 8'h00, 32'h0);

    // Per-cycle vectors: drive on falling edge, check just after the rising edge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; sram_ry = vt[i].ry;
      req0 = vt[i].req0; we0 = vt[i].we0; addr0 = vt[i].addr0; wdata0 = vt[i].wdata0;
      req1 = vt[i].req1; we1 = vt[i].we1; addr1 = vt[i].addr1;
      @(posedge clk); #1;
      check($sformatf("v%0d_gnt", i),   32'({gnt1, gnt0}),       32'(vt[i].gnt));
      check($sformatf("v%0d_rvalid", i), 32'({rvalid1, rvalid0}), 32'(vt[i].rv));
      check($sformatf("v%0d_busy", i),  32'(busy),               32'(vt[i].busy));
      check($sformatf("v%0d_cs_n", i),  32'(sram_cs_n),          32'(vt[i].cs_n));
      check($sformatf("v%0d_we_n", i),  32'(sram_we_n),          32'(vt[i].we_n));
      check($sformatf("v%0d_addr", i),  32'(sram_addr),          32'(vt[i].addr));
      check($sformatf("v%0d_rdata", i), rdata,                   vt[i].rdata);
    end

    // Contention of two reads right after reset: requester 0 first, then alternate
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    ng = 0; nrv = 0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (gnt0 && gnt1) check("cont_dual_gnt", 32'({gnt1, gnt0}), 32'h1);
      if (gnt0 || gnt1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_id = 32'h0;
`else
        exp_id = 32'(ng % 2);
`endif
        check($sformatf("cont_gnt%0d_id", ng), 32'(gnt1), exp_id);
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (rvalid0 || rvalid1) begin
        check($sformatf("cont_rdata%0d", nrv), rdata, rvalid1 ? 32'hA500_0002 : 32'hA500_0001);
        nrv++;
      end
    end
    check("cont_grants", 32'(ng), 32'd4);
    check("cont_rvalids", 32'(nrv), 32'd4);

    // Back-to-back writes from requester 0 to 0x00..0x07
    @(negedge clk);
    base = wr_log.size();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h00; wdata0 = 32'hB000_0000;
    ng = 0; lastc = 0;
    for (int c = 0; c < 40 && req0; c++) begin
      @(posedge clk); #1;
      if (gnt1) check("b2b_gnt1", 32'(gnt1), 32'h0);
      if (gnt0) begin
        if (ng > 0) check($sformatf("b2b_gap%0d", ng), 32'(c - lastc), 32'd2);
        lastc = c;
        ng++;
        if (ng == 8) req0 = 1'b0;
        else begin
          addr0  = ADDR_W'(ng);
          wdata0 = 32'hB000_0000 + 32'(ng);
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("b2b_grants", 32'(ng), 32'd8);
    check("b2b_writes", 32'(wr_log.size() - base), 32'd8);
    if (wr_log.size() - base == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b_order%0d", i), 32'(wr_log[base + i]), 32'(i));
        check($sformatf("b2b_mem%0d", i), mem[i], 32'hB000_0000 + 32'(i));
      end
    end
    check("end_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
